// File: rtl/seg7_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus; one settle FSM shared by all digits.
// Optional macro SEG7_CAPTURE_ALT_GLYPH_EN also decodes the alternate 7 and 9 glyphs.
module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [6:0]              SEGMENTS,
  input  logic [NUM_DIGITS-1:0]   DIGIT_SEL,
  input  logic                    CLEAR,
  output logic [4*NUM_DIGITS-1:0] VALUE,
  output logic [NUM_DIGITS-1:0]   DIGIT_VALID,
  output logic                    ERROR,
  output logic                    FRAME_DONE
);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [6:0]            seg_q, seg_prev;
  logic [NUM_DIGITS-1:0] sel_q, sel_prev;
  logic [1:0]            state, state_n;
  logic [7:0]            count, count_n;
  logic [NUM_DIGITS-1:0] mask, mask_n;
  logic                  accept, sel_ok, same, frame_full, err_n;
  logic [3:0]            nib;
  logic                  pat_hex, pat_blank;

  always_comb begin
    nib       = 4'h0;
    pat_hex   = 1'b1;
    pat_blank = 1'b0;
    case (seg_q)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0011000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
`ifdef SEG7_CAPTURE_ALT_GLYPH_EN
      7'b0010000: nib = 4'h9;
      7'b1011000: nib = 4'h7;
`endif
      7'b1111111: begin
        pat_hex   = 1'b0;
        pat_blank = 1'b1;
      end
      default: pat_hex = 1'b0;
    endcase
  end

  assign sel_ok = ($countones(~sel_q) == 1);
  assign same   = (seg_q == seg_prev) && (sel_q == sel_prev);

  // Count of consecutive identical samples; reaching STABLE_MAX in SETTLE is the accept.
  always_comb begin
    state_n = state;
    count_n = count;
    accept  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (sel_ok) begin
          state_n = ST_SETTLE;
          count_n = 8'd1;
        end else begin
          count_n = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (!sel_ok) begin
          state_n = ST_WAIT;
          count_n = 8'd0;
        end else if (!same) begin
          count_n = 8'd1;
        end else begin
          count_n = (count >= STABLE_MAX) ? STABLE_MAX : count + 8'd1;
          if (count_n == STABLE_MAX) begin
            accept  = 1'b1;
            state_n = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!sel_ok) begin
          state_n = ST_WAIT;
          count_n = 8'd0;
        end else if (!same) begin
          state_n = ST_SETTLE;
          count_n = 8'd1;
        end
      end
      default: begin
        state_n = ST_WAIT;
        count_n = 8'd0;
      end
    endcase
  end

  // CLEAR acts first, so a coinciding accept still lands its mask bit and error result.
  assign mask_n     = (CLEAR ? '0 : mask) | (accept ? ~sel_q : '0);
  assign frame_full = &mask_n;
  assign err_n      = (ERROR & ~CLEAR) | (accept & ~pat_hex & ~pat_blank);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      seg_q       <= '1;
      sel_q       <= '1;
      seg_prev    <= '1;
      sel_prev    <= '1;
      state       <= ST_WAIT;
      count       <= 8'd0;
      mask        <= '0;
      VALUE       <= '0;
      DIGIT_VALID <= '0;
      ERROR       <= 1'b0;
      FRAME_DONE  <= 1'b0;
    end else begin
      seg_q      <= SEGMENTS;
      sel_q      <= DIGIT_SEL;
      seg_prev   <= seg_q;
      sel_prev   <= sel_q;
      state      <= state_n;
      count      <= count_n;
      mask       <= frame_full ? '0 : mask_n;
      FRAME_DONE <= frame_full;
      ERROR      <= err_n;
      if (accept) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (!sel_q[i]) begin
            if (pat_hex) begin
              VALUE[4*i +: 4] <= nib;
              DIGIT_VALID[i]  <= 1'b1;
            end else if (pat_blank) begin
              VALUE[4*i +: 4] <= 4'h0;
              DIGIT_VALID[i]  <= 1'b0;
            end else begin
              DIGIT_VALID[i]  <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Observes a multiplexed, active-low seven-segment display bus and recovers the hexadecimal digits being shown. This is the inverse of the hex-to-segment encoding used by the display drivers. It sits beside a display driver in self-check and loopback builds. It turns segment and anode activity back into a packed nibble vector plus status, so the displayed value can be compared with the ALU result.

## Interface
- NUM_DIGITS, 4, number of multiplexed digit positions (1–8)
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (2–255)

- CLK  input  1  single clock, rising edge
- RESET  input  1  synchronous, active-high reset
- SEGMENTS  input  7  active-low pattern {SEGG,SEGF,SEGE,SEGD,SEGC,SEGB,SEGA}
- DIGIT_SEL  input  NUM_DIGITS  active-low digit enables; a valid selection has exactly one bit low
- CLEAR  input  1  synchronous clear of ERROR and the frame mask
- VALUE  output  4*NUM_DIGITS  recovered nibbles; digit i occupies [4i+3:4i]
- DIGIT_VALID  output  NUM_DIGITS  digit i holds a decoded, non-blank value
- ERROR  output  1  sticky flag: an unrecognised pattern was accepted
- FRAME_DONE  output  1  one-cycle pulse when every digit has been accepted since the last pulse, CLEAR or RESET

## Operation
- Input stage: SEGMENTS and DIGIT_SEL are registered every cycle. All decisions use the registered copy, called the sample.
- Decode table maps 7'b1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0011000,0001000,0000011,1000110,0100001,0000110,0001110 to 0x0–0xF respectively.
- Blank pattern is 7'b1111111. Any other pattern is invalid.
- FSM, one instance shared across digits:
  - WAIT: sample selection is not one-hot-low. Counter = 0. Go to SETTLE when the selection becomes one-hot-low.
  - SETTLE: count consecutive samples equal to the previous sample.
    - If a sample differs, restart the count at 1.
    - If the selection becomes not one-hot-low, go to WAIT.
    - When the count reaches STABLE_CYCLES, perform the accept and go to HOLD.
  - HOLD: at most one accept per stable run. Any change in the sample returns to SETTLE with count 1, or to WAIT if the selection is not one-hot-low.
- Accept for selected digit i:
  - Valid pattern: VALUE[i] = decoded nibble, DIGIT_VALID[i] = 1.
  - Blank: VALUE[i] = 0, DIGIT_VALID[i] = 0.
  - Invalid: VALUE[i] unchanged, DIGIT_VALID[i] = 0, ERROR = 1.
  - In all three cases, set frame mask bit i.
- When the frame mask becomes all-ones: pulse FRAME_DONE and clear the mask in the same edge.
- Other digits' VALUE and DIGIT_VALID never change on an accept.
- CLEAR: ERROR = 0 and mask = 0. VALUE, DIGIT_VALID and FSM are unaffected.
  - If an accept coincides with CLEAR, apply the accept's VALUE/DIGIT_VALID update.
  - The accept's mask bit is set after the clear, so the mask equals only that bit.
  - ERROR equals the accept's error result.
- Width rules: the counter is 8 bits and saturates at STABLE_CYCLES. DIGIT_SEL bits above NUM_DIGITS do not exist.

## Timing
- Reset values: VALUE = 0, DIGIT_VALID = 0, ERROR = 0, FRAME_DONE = 0, mask = 0, FSM = WAIT, input register = all ones.
- Latency: a pin pattern is stable from the edge at which it is first registered (edge 0). It is accepted at edge STABLE_CYCLES−1 after that. Outputs are visible from edge STABLE_CYCLES, i.e. STABLE_CYCLES+1 edges from pins to outputs.
- FRAME_DONE asserts in the same cycle the completing accept becomes visible. It lasts exactly one cycle.
- A glitch of one or more cycles during SETTLE delays acceptance by a full STABLE_CYCLES run. No partial credit is kept.
- RESET mid-run takes priority over everything. The FSM resumes in WAIT regardless of the pins.

## Configuration
- SEG7_CAPTURE_ALT_GLYPH_EN defined: two alternate glyphs are also decoded.
  - 7'b0010000 (nine with SEGD lit) decodes to 0x9.
  - 7'b1011000 (seven with SEGF lit) decodes to 0x7.
- Undefined: both alternate patterns are invalid and set ERROR.

## Test plan
- Reset, then digit 0 selected (DIGIT_SEL=4'b1110) with SEGMENTS=7'b0110000 held for 4 cycles -> VALUE=16'h0003, DIGIT_VALID=4'b0001, ERROR=0.
- Cycle digits 0–3 with patterns A,B,C,D, each held for 6 cycles -> VALUE=16'hDCBA, DIGIT_VALID=4'b1111, FRAME_DONE pulses once after digit 3.
- Digit 1 shows 7'b1111000 for 3 cycles, then one glitch cycle, then 4 stable cycles -> a single accept 5 edges after the glitch, VALUE[7:4]=7, no earlier update.
- DIGIT_SEL=4'b1100 held for 10 cycles -> no accept, outputs unchanged. Then 4'b1111 -> WAIT, no change.
- Digit 2 shows 7'b0010000 for 4 cycles:
  - Macro undefined -> ERROR=1, DIGIT_VALID[2]=0.
  - Macro defined -> VALUE[11:8]=9, ERROR=0.
  - In both builds, CLEAR then clears ERROR.
- RESET asserted mid-SETTLE and on the FRAME_DONE cycle -> all outputs 0 next edge. The first accept after release needs a full STABLE_CYCLES run.
